// File: rtl/sdram_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : sdram_arbiter
// Brief    : Two-master SDRAM arbiter with bounded run lengths and read-tag FIFO.
// Revision : 1.0
//------------------------------------------------------------------------------
module sdram_arbiter #(
    parameter int M0_RUN_LIMIT = 32,
    parameter int M1_RUN_LIMIT = 4,
    parameter int TAG_DEPTH    = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [28:0] m0_address,
    input  logic        m0_read,
    output logic        m0_waitrequest,
    output logic [63:0] m0_readdata,
    output logic        m0_readdatavalid,
    input  logic [28:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [63:0] m1_writedata,
    input  logic [7:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [63:0] m1_readdata,
    output logic        m1_readdatavalid,
    output logic [28:0] s_address,
    output logic [7:0]  s_burstcount,
    output logic        s_read,
    output logic        s_write,
    output logic [63:0] s_writedata,
    output logic [7:0]  s_byteenable,
    input  logic        s_waitrequest,
    input  logic [63:0] s_readdata,
    input  logic        s_readdatavalid,
    output logic [6:0]  outstanding,
    output logic        err_orphan
);

    localparam int c_RUN_MAX = (M0_RUN_LIMIT > M1_RUN_LIMIT) ? M0_RUN_LIMIT : M1_RUN_LIMIT;
    localparam int c_RUN_W   = $clog2(c_RUN_MAX + 1);
    localparam int c_PTR_W   = $clog2(TAG_DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;

    localparam logic [c_RUN_W-1:0] c_M0_LIMIT = c_RUN_W'(M0_RUN_LIMIT);
    localparam logic [c_RUN_W-1:0] c_M1_LIMIT = c_RUN_W'(M1_RUN_LIMIT);
    localparam logic [c_RUN_W-1:0] c_RUN_ONE  = c_RUN_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(TAG_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [c_RUN_W-1:0]   run_q, run_d;
    logic [c_PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [c_CNT_W-1:0]   count_q;
    logic                 err_orphan_q;
    logic                 tag_mem_q [TAG_DEPTH];

    logic                 w_req0, w_req1;
    logic                 w_full, w_empty;
    logic                 w_accept, w_push, w_pop;
    logic                 w_owner, w_head;
    logic [c_RUN_W-1:0]   w_run_inc;

    assign w_req0    = m0_read;
    assign w_req1    = m1_read | m1_write;
    assign w_full    = (count_q == c_DEPTH);
    assign w_empty   = (count_q == '0);
    assign w_accept  = (s_read | s_write) & ~s_waitrequest;
    assign w_push    = s_read & ~s_waitrequest;
    assign w_pop     = s_readdatavalid & ~w_empty;
    assign w_owner   = (state_q == ST_GRANT1);
    assign w_head    = tag_mem_q[rd_ptr_q];
    assign w_run_inc = run_q + c_RUN_ONE;

    // Command mux; a full tag FIFO blocks reads but lets writes through.
    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (state_q)
            ST_GRANT0: begin
                s_address      = m0_address;
                s_read         = m0_read & ~w_full;
                s_byteenable   = 8'hFF;
                m0_waitrequest = s_waitrequest | w_full;
            end
            ST_GRANT1: begin
                s_address      = m1_address;
                s_read         = m1_read & ~w_full;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_waitrequest = s_waitrequest | (m1_read & w_full);
            end
            default: begin
            end
        endcase
    end

    // Stalled commands never change grant: no accept means no transition
    // while the owner keeps requesting.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        case (state_q)
            ST_IDLE: begin
                if (w_req0) begin
                    state_d = ST_GRANT0;
                end else if (w_req1) begin
                    state_d = ST_GRANT1;
                end
            end
            ST_GRANT0: begin
                if (!w_req0) begin
                    state_d = w_req1 ? ST_GRANT1 : ST_IDLE;
                    run_d   = '0;
                end else if (w_accept && w_req1) begin
                    if (w_run_inc >= c_M0_LIMIT) begin
                        state_d = ST_GRANT1;
                        run_d   = '0;
                    end else begin
                        run_d = w_run_inc;
                    end
                end
            end
            ST_GRANT1: begin
                if (!w_req1) begin
                    state_d = w_req0 ? ST_GRANT0 : ST_IDLE;
                    run_d   = '0;
                end else if (w_accept && w_req0) begin
                    if (w_run_inc >= c_M1_LIMIT) begin
                        state_d = ST_GRANT0;
                        run_d   = '0;
                    end else begin
                        run_d = w_run_inc;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                run_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + c_CNT_ONE;
                2'b01:   count_q <= count_q - c_CNT_ONE;
                default: count_q <= count_q;
            endcase
            if (s_readdatavalid && w_empty) begin
                err_orphan_q <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read while occupied.
    always_ff @(posedge clock) begin
        if (w_push) begin
            tag_mem_q[wr_ptr_q] <= w_owner;
        end
    end

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = w_pop & ~w_head;
    assign m1_readdatavalid = w_pop & w_head;
    assign s_burstcount     = 8'h01;
    assign outstanding      = 7'(count_q);
    assign err_orphan       = err_orphan_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_sdram_arbiter
// Brief    : Directed self-checking bench for sdram_arbiter.
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_sdram_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [28:0] m0_address;
    logic        m0_read;
    logic        m0_waitrequest;
    logic [63:0] m0_readdata;
    logic        m0_readdatavalid;
    logic [28:0] m1_address;
    logic        m1_read;
    logic        m1_write;
    logic [63:0] m1_writedata;
    logic [7:0]  m1_byteenable;
    logic        m1_waitrequest;
    logic [63:0] m1_readdata;
    logic        m1_readdatavalid;
    logic [28:0] s_address;
    logic [7:0]  s_burstcount;
    logic        s_read;
    logic        s_write;
    logic [63:0] s_writedata;
    logic [7:0]  s_byteenable;
    logic        s_waitrequest;
    logic [63:0] s_readdata;
    logic        s_readdatavalid;
    logic [6:0]  outstanding;
    logic        err_orphan;

    int tests = 0;
    int fails = 0;

    sdram_arbiter dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_byteenable    (m1_byteenable),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_burstcount     (s_burstcount),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_byteenable     (s_byteenable),
        .s_waitrequest    (s_waitrequest),
        .s_readdata       (s_readdata),
        .s_readdatavalid  (s_readdatavalid),
        .outstanding      (outstanding),
        .err_orphan       (err_orphan)
    );

    always #5 clock = ~clock;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_w;
        reset_n = 1'b0; m0_address = '0; m0_read = 1'b0;
        m1_address = '0; m1_read = 1'b0; m1_write = 1'b0;
        m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
        #2;
        chk1("rst_s_read", s_read, 1'b0);
        chk1("rst_s_write", s_write, 1'b0);
        chk1("rst_m0_wait", m0_waitrequest, 1'b1);
        chk1("rst_m1_wait", m1_waitrequest, 1'b1);
        chkw("rst_outstanding", 64'(outstanding), 64'd0);
        chk1("rst_orphan", err_orphan, 1'b0);
        chkw("burstcount", 64'(s_burstcount), 64'h01);
        tick; tick; reset_n = 1'b1;

        // Single master streaming reads
        tick; m0_read = 1'b1; m0_address = 29'h100; #1;
        chk1("idle_no_read", s_read, 1'b0);
        chk1("idle_m0_wait", m0_waitrequest, 1'b1);
        tick; #1;
        chk1("g0_read", s_read, 1'b1);
        chkw("g0_addr", 64'(s_address), 64'h100);
        chk1("g0_m0_wait", m0_waitrequest, 1'b0);
        chkw("g0_be", 64'(s_byteenable), 64'hFF);
        chk1("g0_no_write", s_write, 1'b0);
        chkw("g0_out0", 64'(outstanding), 64'd0);
        tick; m0_address = 29'h101; #1;
        chk1("g0_read2", s_read, 1'b1);
        chkw("g0_addr2", 64'(s_address), 64'h101);
        chkw("g0_out1", 64'(outstanding), 64'd1);
        tick; m0_read = 1'b0; s_readdatavalid = 1'b1; s_readdata = 64'hA0; #1;
        chk1("g0_drop", s_read, 1'b0);
        chkw("g0_out2", 64'(outstanding), 64'd2);
        chk1("ret0_m0v", m0_readdatavalid, 1'b1);
        chk1("ret0_m1v", m1_readdatavalid, 1'b0);
        chkw("ret0_data", m0_readdata, 64'hA0);
        tick; s_readdata = 64'hA1; #1;
        chkw("ret1_out", 64'(outstanding), 64'd1);
        chk1("ret1_m0v", m0_readdatavalid, 1'b1);
        chkw("ret1_data", m0_readdata, 64'hA1);
        tick; s_readdatavalid = 1'b0; #1;
        chkw("ret_out0", 64'(outstanding), 64'd0);
        chk1("ret_m0v_low", m0_readdatavalid, 1'b0);

        // Both masters busy: 32 m0 reads then 4 m1 writes, no gaps
        tick; m0_read = 1'b1; m0_address = 29'h200; m1_write = 1'b1;
        m1_address = 29'h300; m1_writedata = 64'hDEAD_BEEF_0000_0001; m1_byteenable = 8'h0F; #1;
        for (int i = 0; i < 40; i++) begin
            tick; #1;
            exp_w = (i >= 32) && (i < 36);
            chk1("arb_read", s_read, !exp_w);
            chk1("arb_write", s_write, exp_w);
            chkw("arb_addr", 64'(s_address), exp_w ? 64'h300 : 64'h200);
        end
        tick; m1_write = 1'b0; #1;
        chkw("arb_out36", 64'(outstanding), 64'd36);

        // Fill the tag FIFO to 64
        repeat (28) tick;
        chkw("full_out", 64'(outstanding), 64'd64);
        chk1("full_no_read", s_read, 1'b0);
        chk1("full_m0_wait", m0_waitrequest, 1'b1);
        tick;
        chk1("full_hold", s_read, 1'b0);
        tick; s_readdatavalid = 1'b1; s_readdata = 64'hC0; #1;
        chk1("full_pop_no_read", s_read, 1'b0);
        chk1("full_pop_wait", m0_waitrequest, 1'b1);
        chk1("full_pop_m0v", m0_readdatavalid, 1'b1);
        tick; s_readdatavalid = 1'b0; #1;
        chkw("after_pop_out", 64'(outstanding), 64'd63);
        chk1("after_pop_read", s_read, 1'b1);
        chk1("after_pop_wait", m0_waitrequest, 1'b0);
        tick; m0_read = 1'b0; #1;
        chkw("refull_out", 64'(outstanding), 64'd64);
        for (int i = 0; i < 64; i++) begin
            tick; s_readdatavalid = 1'b1; #1;
            chk1("drain_m0v", m0_readdatavalid, 1'b1);
            chk1("drain_m1v", m1_readdatavalid, 1'b0);
        end
        tick; s_readdatavalid = 1'b0; #1;
        chkw("drain_out", 64'(outstanding), 64'd0);
        chk1("drain_no_orphan", err_orphan, 1'b0);

        // Interleaved m0, m1, m0 reads and in-order returns
        tick; m0_read = 1'b1; m0_address = 29'h10; #1;
        chk1("il_idle", s_read, 1'b0);
        tick; #1;
        chk1("il_r0", s_read, 1'b1);
        chkw("il_a0", 64'(s_address), 64'h10);
        tick; m0_read = 1'b0; m1_read = 1'b1; m1_address = 29'h20; #1;
        chk1("il_gap", s_read, 1'b0);
        chk1("il_m1_wait_g0", m1_waitrequest, 1'b1);
        tick; #1;
        chk1("il_r1", s_read, 1'b1);
        chkw("il_a1", 64'(s_address), 64'h20);
        chk1("il_m1_wait", m1_waitrequest, 1'b0);
        chk1("il_m0_wait", m0_waitrequest, 1'b1);
        tick; m1_read = 1'b0; m0_read = 1'b1; #1;
        tick; #1;
        chk1("il_r2", s_read, 1'b1);
        chkw("il_a2", 64'(s_address), 64'h10);
        tick; m0_read = 1'b0; s_readdatavalid = 1'b1; s_readdata = 64'hD1; #1;
        chkw("il_out3", 64'(outstanding), 64'd3);
        chk1("il_ret0_m0v", m0_readdatavalid, 1'b1);
        chk1("il_ret0_m1v", m1_readdatavalid, 1'b0);
        tick; s_readdata = 64'hD2; #1;
        chk1("il_ret1_m0v", m0_readdatavalid, 1'b0);
        chk1("il_ret1_m1v", m1_readdatavalid, 1'b1);
        chkw("il_ret1_data", m1_readdata, 64'hD2);
        tick; s_readdata = 64'hD3; #1;
        chk1("il_ret2_m0v", m0_readdatavalid, 1'b1);
        chk1("il_ret2_m1v", m1_readdatavalid, 1'b0);
        tick; s_readdatavalid = 1'b0; #1;
        chkw("il_out0", 64'(outstanding), 64'd0);

        // Stalled m1 write holds command and grant
        tick; m1_write = 1'b1; m1_address = 29'h55; m1_writedata = 64'h1122_3344_5566_7788;
        m1_byteenable = 8'hA5; s_waitrequest = 1'b1; #1;
        chk1("st_idle", s_write, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick; m0_read = 1'b1; #1;
            chk1("st_write", s_write, 1'b1);
            chk1("st_no_read", s_read, 1'b0);
            chkw("st_addr", 64'(s_address), 64'h55);
            chkw("st_wdata", s_writedata, 64'h1122_3344_5566_7788);
            chkw("st_be", 64'(s_byteenable), 64'hA5);
            chk1("st_m1_wait", m1_waitrequest, 1'b1);
            chk1("st_m0_wait", m0_waitrequest, 1'b1);
        end
        tick; s_waitrequest = 1'b0; #1;
        chk1("st_accept_write", s_write, 1'b1);
        chk1("st_accept_wait", m1_waitrequest, 1'b0);
        tick; m1_write = 1'b0; #1;
        chk1("st_drop_write", s_write, 1'b0);
        chk1("st_drop_read", s_read, 1'b0);
        tick; s_waitrequest = 1'b1; #1;
        chk1("st_g0_read", s_read, 1'b1);
        chkw("st_g0_addr", 64'(s_address), 64'h10);
        chk1("st_g0_wait", m0_waitrequest, 1'b1);
        tick; m0_read = 1'b0; s_waitrequest = 1'b0; #1;
        chkw("st_out0", 64'(outstanding), 64'd0);

        // Reset discards tags; late return becomes orphan
        tick; m0_read = 1'b1; #1;
        tick; #1;
        tick; m0_read = 1'b0; #1;
        chkw("pre_rst_out", 64'(outstanding), 64'd1);
        reset_n = 1'b0; #1;
        chkw("async_rst_out", 64'(outstanding), 64'd0);
        chk1("async_rst_wait", m0_waitrequest, 1'b1);
        chk1("async_rst_read", s_read, 1'b0);
        tick; reset_n = 1'b1; #1;
        tick; s_readdatavalid = 1'b1; s_readdata = 64'hE0; #1;
        chk1("orph_m0v", m0_readdatavalid, 1'b0);
        chk1("orph_m1v", m1_readdatavalid, 1'b0);
        chk1("orph_not_yet", err_orphan, 1'b0);
        tick; s_readdatavalid = 1'b0; #1;
        chk1("orph_set", err_orphan, 1'b1);
        repeat (3) tick;
        chk1("orph_sticky", err_orphan, 1'b1);
        reset_n = 1'b0; #1;
        chk1("orph_cleared", err_orphan, 1'b0);
        tick; reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter M0_RUN_LIMIT, default 32: max consecutive m0 commands accepted while m1 is waiting.
REQ-002 Parameter M1_RUN_LIMIT, default 4: max consecutive m1 commands accepted while m0 is waiting.
REQ-003 Parameter TAG_DEPTH, default 64 (power of 2): max outstanding reads.
REQ-004 Ports, in order:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- m0_address  in  29  frame-buffer read address, 64-bit word units.
- m0_read  in  1  frame-buffer read request.
- m0_waitrequest  out  1  frame-buffer stall.
- m0_readdata  out  64  frame-buffer read data.
- m0_readdatavalid  out  1  frame-buffer data valid.
- m1_address  in  29  rasterizer address.
- m1_read / m1_write  in  1 each  rasterizer read / write request.
- m1_writedata  in  64  write data.
- m1_byteenable  in  8  write byte enables.
- m1_waitrequest  out  1  rasterizer stall.
- m1_readdata  out  64  rasterizer read data.
- m1_readdatavalid  out  1  rasterizer data valid.
- s_address  out  29  SDRAM address.
- s_burstcount  out  8  constant 8'h01.
- s_read / s_write  out  1 each  SDRAM command.
- s_writedata  out  64  SDRAM write data.
- s_byteenable  out  8  SDRAM byte enables.
- s_waitrequest  in  1  SDRAM stall.
- s_readdata  in  64  SDRAM read data.
- s_readdatavalid  in  1  SDRAM data valid.
- outstanding  out  7  reads in flight (tag FIFO occupancy).
- err_orphan  out  1  sticky: readdatavalid received with no read outstanding.

Function
REQ-005 States: IDLE, GRANT0, GRANT1; registered; one-hot or binary, implementer's choice.
REQ-006 Requests: req0 = m0_read; req1 = m1_read | m1_write.
REQ-007 IDLE: s_read = s_write = 0; both waitrequests = 1; next state GRANT0 if req0, else GRANT1 if req1, else IDLE; first command reaches the slave 1 cycle after the request.
REQ-008 GRANTx: s_address, s_read, s_write, s_writedata, s_byteenable driven combinationally from master x; for m0, s_write = 0 and s_byteenable = 8'hFF; mx_waitrequest = s_waitrequest; the other master's waitrequest = 1.
REQ-009 Accept in GRANTx: cycle with (s_read | s_write) & !s_waitrequest.
REQ-010 GRANTx transitions:
- !reqx -> GRANT(other) if other requesting, else IDLE; run counter cleared.
- On accept: run counter +1. If the other master is requesting and the counter reaches the limit for x, next state is GRANT(other) and the counter clears.
- Otherwise stay in GRANTx; the command is held while s_waitrequest is high.
REQ-011 The run counter is not incremented and the limit is not applied while the other master is not requesting.
REQ-012 Grant never changes while a command is stalled: the state is held while s_waitrequest = 1 and a command is asserted.
REQ-013 Tag FIFO: 1-bit owner entries, TAG_DEPTH deep.
- Push on an accepted read, with the owner of the current grant.
- Pop on s_readdatavalid.
- Simultaneous push and pop leave the occupancy unchanged.
REQ-014 Tag FIFO full: the granted read is suppressed (s_read = 0, mx_waitrequest = 1), even if a pop occurs in the same cycle; writes are unaffected.
REQ-015 s_readdata is broadcast combinationally to m0_readdata and m1_readdata.
REQ-016 Read return: m0_readdatavalid = s_readdatavalid & head==0; m1_readdatavalid = s_readdatavalid & head==1; zero latency.
REQ-017 s_readdatavalid with an empty FIFO: no master valid asserted; err_orphan set to 1 and held until reset.
REQ-018 outstanding equals the tag FIFO occupancy, 0..TAG_DEPTH.

Reset
REQ-019 Asynchronous reset_n low forces:
- state IDLE, run counter 0, FIFO empty.
- outstanding 0, err_orphan 0.
- s_read = s_write = 0, both waitrequests = 1.
REQ-020 Reset mid-operation discards all outstanding tags; data returning after reset is treated as orphan (REQ-017).

Verification
REQ-021 m0_read held, SDRAM never stalls, m1 idle -> first s_read at cycle 2, then one read per cycle; m0_readdatavalid per return, outstanding tracks in-flight reads.
REQ-022 m0 and m1 both requesting continuously, limits 32/4 -> repeating pattern of 32 m0 accepts then 4 m1 accepts, no idle cycles between grants.
REQ-023 m1_write with s_waitrequest high for 5 cycles while m0_read asserts -> s_address/s_writedata stable all 5 cycles; grant stays GRANT1 until accept.
REQ-024 Interleaved reads: m0, m1, m0 accepted; SDRAM returns 3 words in order -> valids on m0, m1, m0 respectively.
REQ-025 64 reads outstanding, no returns -> s_read held 0 and m0_waitrequest 1; one return -> next read accepted the following cycle.
REQ-026 s_readdatavalid pulse after reset with no reads -> no master valid, err_orphan = 1 until reset_n pulse.
